// File: rtl/data_sram_ctrl.sv
// Data-side SRAM access controller: accepts one load/store from execute, strobes
// the SRAM, waits for ack with a bounded timeout, and returns an extended result.
module data_sram_ctrl #(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        stallreq,
   output logic        data_sram_en,
   output logic [3:0]  data_sram_wen,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   input  logic [31:0] data_sram_rdata,
   input  logic        data_sram_ack,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        misalign,
   output logic        timeout
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

   localparam int CNT_W = $clog2(WAIT_MAX + 1);
   // Last WAIT count: its increment would reach WAIT_MAX-1, so timeout lands
   // WAIT_MAX cycles after ACCESS.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 2);

   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we, r_signed, r_timeout, r_misalign;
   logic [1:0]        r_size;
   logic [31:0]       r_addr, r_wdata, r_rdata;
   logic              w_misaligned, w_accept, w_expire;

   function automatic logic [3:0] f_wen(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   f_wen = 4'b0001 << a;
         2'b01:   f_wen = 4'b0011 << {a[1], 1'b0};
         2'b10:   f_wen = 4'b1111;
         default: f_wen = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] f_lanes(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   f_lanes = {4{d[7:0]}};
         2'b01:   f_lanes = {2{d[15:0]}};
         default: f_lanes = d;
      endcase
   endfunction

   function automatic logic [31:0] f_extract(input logic [1:0] size, input logic sgn,
                                             input logic [1:0] a, input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[{a, 3'b000} +: 8];
      h = d[{a[1], 4'b0000} +: 16];
      case (size)
         2'b00:   f_extract = {{24{sgn & b[7]}}, b};
         2'b01:   f_extract = {{16{sgn & h[15]}}, h};
         default: f_extract = d;
      endcase
   endfunction

   assign w_misaligned = (req_size == 2'b11) ||
                         (req_size == 2'b01 && req_addr[0]) ||
                         (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   assign w_accept = (r_state == S_IDLE) && req_valid && !w_misaligned;
   assign w_expire = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = S_ACCESS;
         S_ACCESS: w_next = S_WAIT;
         S_WAIT:   if (data_sram_ack || w_expire) w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_size     <= 2'b00;
         r_signed   <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_timeout  <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= (r_state == S_IDLE) && req_valid && w_misaligned;
         if (w_accept) begin
            r_we      <= req_we;
            r_size    <= req_size;
            r_signed  <= req_signed;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
         end
         case (r_state)
            S_ACCESS: r_cnt <= '0;
            S_WAIT: begin
               if (data_sram_ack) begin
                  r_rdata <= data_sram_rdata;
               end else if (w_expire) begin
                  r_timeout <= 1'b1;
                  r_rdata   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready       = (r_state == S_IDLE);
      stallreq        = (r_state == S_ACCESS) || (r_state == S_WAIT);
      data_sram_en    = 1'b0;
      data_sram_wen   = 4'b0000;
      data_sram_addr  = '0;
      data_sram_wdata = '0;
      rsp_valid       = 1'b0;
      rsp_rdata       = '0;
      timeout         = 1'b0;
      misalign        = r_misalign;
      if (r_state == S_ACCESS) begin
         data_sram_en   = 1'b1;
         data_sram_addr = {r_addr[31:2], 2'b00};
         if (r_we) begin
            data_sram_wen   = f_wen(r_size, r_addr[1:0]);
            data_sram_wdata = f_lanes(r_size, r_wdata);
         end
      end
      if (r_state == S_RESP) begin
         rsp_valid = 1'b1;
         timeout   = r_timeout;
         if (!r_we) rsp_rdata = f_extract(r_size, r_signed, r_addr[1:0], r_rdata);
      end
   end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Bench for data_sram_ctrl: directed and random transactions checked cycle by
// cycle against an arithmetic model of the access rules.
module tb_data_sram_ctrl;

   localparam int WAIT_MAX = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, stallreq, data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
   logic        data_sram_ack;
   logic        rsp_valid, misalign, timeout;
   logic [31:0] rsp_rdata;

   int tests = 0;
   int fails = 0;

   data_sram_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .stallreq(stallreq),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata), .data_sram_ack(data_sram_ack),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .misalign(misalign), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic logic [3:0] m_wen(input logic [1:0] sz, input logic [31:0] a);
      int unsigned v;
      if (sz == 2'd0)      v = 1 << (a % 4);
      else if (sz == 2'd1) v = 3 << (2 * ((a / 2) % 2));
      else                 v = 15;
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
      if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
      if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg,
                                          input logic [31:0] a, input logic [31:0] rd);
      int unsigned v;
      if (sz == 2'd0) begin
         v = (rd >> (8 * (a % 4))) & 32'hFF;
         if (sg && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (sg && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // Called at a negedge while idle; d = WAIT cycles before ack, d < 0 withholds ack.
   task automatic run_txn(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int d);
      bit          mis, to;
      int          rsp_cyc;
      logic [31:0] exp_rsp;
      mis = m_misaligned(sz, a);
      chk("idle_ready", req_ready, 1'b1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      @(negedge clk);
      if (mis) begin
         req_valid = 1'b0;
         chk("mis_pulse", misalign, 1'b1);
         chk("mis_no_en", data_sram_en, 1'b0);
         chk("mis_ready", req_ready, 1'b1);
         chk("mis_stall", stallreq, 1'b0);
         @(negedge clk);
         chk("mis_clear", misalign, 1'b0);
         chk("mis_no_en2", data_sram_en, 1'b0);
         return;
      end
      // Busy: random request traffic and a spurious ack must be ignored.
      req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      data_sram_ack = 1'b1; data_sram_rdata = ~rd;
      chk("acc_en", data_sram_en, 1'b1);
      chk("acc_addr", data_sram_addr, a & 32'hFFFF_FFFC);
      chk("acc_wen", data_sram_wen, we ? m_wen(sz, a) : 4'b0000);
      if (we) chk("acc_wdata", data_sram_wdata, m_wdata(sz, wd));
      chk("acc_stall", stallreq, 1'b1);
      chk("acc_ready", req_ready, 1'b0);
      to      = (d < 0) || (d >= WAIT_MAX - 1);
      rsp_cyc = to ? 1 + WAIT_MAX : 3 + d;
      exp_rsp = (to || we) ? 32'h0 : m_load(sz, sg, a, rd);
      for (int cyc = 2; cyc <= rsp_cyc + 1; cyc++) begin
         @(negedge clk);
         data_sram_ack   = (!to && cyc == 2 + d) || (to && cyc >= rsp_cyc);
         data_sram_rdata = (!to && cyc == 2 + d) ? rd : $urandom;
         if (cyc <= rsp_cyc) begin
            chk("busy_en", data_sram_en, 1'b0);
            chk("busy_addr", data_sram_addr, 32'h0);
            chk("rsp_valid", rsp_valid, (cyc == rsp_cyc));
            chk("stallreq", stallreq, (cyc < rsp_cyc));
         end
         if (cyc == rsp_cyc) begin
            chk("rsp_rdata", rsp_rdata, exp_rsp);
            chk("rsp_timeout", timeout, to);
            req_valid = 1'b0;
         end
         if (cyc == rsp_cyc + 1) begin
            chk("post_ready", req_ready, 1'b1);
            chk("post_rsp", rsp_valid, 1'b0);
            chk("post_to", timeout, 1'b0);
            chk("post_stall", stallreq, 1'b0);
            req_valid = 1'b0;
         end
      end
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0; data_sram_rdata = '0; data_sram_ack = 1'b0;
      #2;
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_stall", stallreq, 1'b0);
      chk("rst_en", data_sram_en, 1'b0);
      chk("rst_wen", data_sram_wen, 4'b0000);
      chk("rst_rsp", rsp_valid, 1'b0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_mis", misalign, 1'b0);
      chk("rst_to", timeout, 1'b0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);

      run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 0);
      run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 1);
      run_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'h12345678, 0);
      run_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 0);
      run_txn(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, -1);
      run_txn(1'b0, 2'd1, 1'b1, 32'h306, 32'h0, 32'h9ABC1234, 2);
      run_txn(1'b1, 2'd0, 1'b0, 32'h401, 32'h000000A5, 32'h0, 3);

      // Reset in the middle of WAIT abandons the access.
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h500;
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      chk("wait_stall", stallreq, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("arst_ready", req_ready, 1'b1);
      chk("arst_stall", stallreq, 1'b0);
      chk("arst_rsp", rsp_valid, 1'b0);
      chk("arst_en", data_sram_en, 1'b0);
      @(negedge clk); rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("arst_no_rsp", rsp_valid, 1'b0);
         chk("arst_idle", req_ready, 1'b1);
      end
      run_txn(1'b1, 2'd2, 1'b0, 32'h600, 32'h13579BDF, 32'h0, 1);

      for (int i = 0; i < 40; i++) begin
         logic [1:0] sz;
         int         d;
         sz = 2'($urandom);
         d  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
         run_txn(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom, d);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/data_sram_ctrl.md
DATA_SRAM_CTRL -- requirements
Module: data_sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: the maximum number of WAIT-state cycles before a timeout.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  access request from the execute stage.
REQ-005 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-006 SHALL have port req_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port req_signed  in  1  sign-extend load data when 1.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port req_ready  out  1  controller idle, request can be accepted.
REQ-011 SHALL have port stallreq  out  1  pipeline stall request to the stall controller.
REQ-012 SHALL have port data_sram_en  out  1  SRAM access strobe.
REQ-013 SHALL have port data_sram_wen  out  4  SRAM byte write enables.
REQ-014 SHALL have port data_sram_addr  out  32  word-aligned SRAM address.
REQ-015 SHALL have port data_sram_wdata  out  32  lane-replicated store data.
REQ-016 SHALL have port data_sram_rdata  in  32  SRAM read data, valid when data_sram_ack=1.
REQ-017 SHALL have port data_sram_ack  in  1  SRAM completion, one-cycle pulse.
REQ-018 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-019 SHALL have port rsp_rdata  out  32  extended load result (0 for stores).
REQ-020 SHALL have port misalign  out  1  one-cycle pulse: request rejected for alignment.
REQ-021 SHALL have port timeout  out  1  one-cycle pulse, coincident with rsp_valid, when no ack arrived within WAIT_MAX cycles.

Function
REQ-022 SHALL implement a four-state FSM: IDLE, ACCESS, WAIT, RESP.
REQ-023 In IDLE: req_ready=1; in all other states: req_ready=0, and requests are ignored.
REQ-024 Misalignment SHALL be defined as: halfword with addr[0]=1; word with addr[1:0]!=0; or size 11.
REQ-025 IDLE with req_valid and an aligned request SHALL latch we/size/signed/addr/wdata and go to ACCESS next cycle.
REQ-026 IDLE with req_valid and a misaligned request SHALL register misalign=1 for exactly the next cycle, stay in IDLE, and issue no SRAM access.
REQ-027 ACCESS SHALL drive data_sram_en=1 for exactly one cycle with addr={addr[31:2],2'b00}, then go to WAIT.
REQ-028 wen for loads SHALL be 0000; for byte stores SHALL be 0001<<addr[1:0]; for halfword stores SHALL be 0011<<{addr[1],1'b0}; for word stores SHALL be 1111.
REQ-029 wdata for byte stores SHALL be {4{wdata[7:0]}}; for halfword stores SHALL be {2{wdata[15:0]}}; for word stores SHALL be wdata unchanged.
REQ-030 WAIT SHALL use a cycle counter starting at 0; on ack, capture rdata and go to RESP; otherwise increment the counter.
REQ-031 When the counter reaches WAIT_MAX-1 without ack, the FSM SHALL go to RESP with timeout=1 and rsp_rdata=0.
REQ-032 ack SHALL be ignored outside WAIT.
REQ-033 RESP SHALL assert rsp_valid=1 for one cycle, then go to IDLE.
REQ-034 Load extraction SHALL select the byte lane addr[1:0] or halfword lane addr[1], then zero-extend, or sign-extend if signed.
REQ-035 stallreq SHALL be 1 in ACCESS and WAIT and 0 in IDLE and RESP.
REQ-036 Minimum latency SHALL be: accept cycle 0, en cycle 1, ack cycle 2, rsp_valid cycle 3.
REQ-037 data_sram_en/wen/addr/wdata SHALL be zero whenever the FSM is not in ACCESS.

Reset
REQ-038 rst=0 SHALL asynchronously force: state=IDLE, counter=0, all latched fields=0, all outputs 0 except req_ready=1.
REQ-039 Reset asserted mid-transaction SHALL abandon the transaction with no rsp_valid; the first request after release SHALL be accepted normally.

Verification
REQ-040 Word load at addr 0x100, ack at cycle 2 with rdata 0xDEADBEEF -> en=1 only at cycle 1, addr 0x100, wen 0000; rsp_valid at cycle 3 with rsp_rdata 0xDEADBEEF; stallreq=1 at cycles 1-2.
REQ-041 Signed byte load at addr 0x103 with rdata 0x80FFFFFF -> rsp_rdata 0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-042 Halfword store at addr 0x202, wdata 0x0000ABCD -> wen 1100, addr 0x200, wdata 0xABCDABCD, rsp_rdata 0.
REQ-043 Word load at addr 0x101 -> misalign=1 for one cycle, en never asserted, req_ready stays 1.
REQ-044 Load with ack withheld, WAIT_MAX=15 -> rsp_valid with timeout=1 exactly 15 cycles after ACCESS; a later ack is ignored.
REQ-045 rst pulsed low during WAIT -> immediate IDLE, no rsp_valid; a subsequent word store completes normally.
